// File: rtl/lcv_mul_acc_pipe.sv
// Three-stage signed multiply-accumulate (a*b + c + carry_in) with an internal accumulator and op select.
// Latency: 3 cycles from accept to out_valid at one result per cycle. Build with LCV_MUL_ACC_PIPE_SAT_EN to saturate.
// Backpressure: a single global advance (!out_valid | out_ready) freezes all stages; in_ready follows it.
module lcv_mul_acc_pipe #(
  parameter int IN_WIDTH  = 16,
  parameter int ACC_WIDTH = 33
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  a,
  input  logic [IN_WIDTH-1:0]  b,
  input  logic [ACC_WIDTH-1:0] c,
  input  logic                 carry_in,
  input  logic [1:0]           op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] outp,
  output logic                 ovf
);

  localparam int PW = 2 * IN_WIDTH;
`ifdef LCV_MUL_ACC_PIPE_SAT_EN
  // Saturation needs headroom: term at ACC_WIDTH+2, accumulate result at ACC_WIDTH+3.
  localparam int TW = ACC_WIDTH + 2;
  localparam int RW = ACC_WIDTH + 3;
`else
  // Wrapping only keeps the low ACC_WIDTH bits, which wider arithmetic would not change.
  localparam int TW = ACC_WIDTH;
  localparam int RW = ACC_WIDTH;
`endif

  localparam logic [1:0] OP_PASS = 2'd0;
  localparam logic [1:0] OP_LOAD = 2'd1;
  localparam logic [1:0] OP_ACC  = 2'd2;
  localparam logic [1:0] OP_SUB  = 2'd3;

  logic                 adv;
  logic                 v1_q, v1_d, cin1_q, cin1_d;
  logic [IN_WIDTH-1:0]  a1_q, a1_d, b1_q, b1_d;
  logic [ACC_WIDTH-1:0] c1_q, c1_d;
  logic [1:0]           op1_q, op1_d, op2_q, op2_d;
  logic                 v2_q, v2_d;
  logic [TW-1:0]        t2_q, t2_d;
  logic                 out_valid_q, out_valid_d;
  logic [ACC_WIDTH-1:0] outp_q, outp_d, acc_q, acc_d;

  logic [PW-1:0]        a_x, b_x, prod;
  logic [TW-1:0]        term;
  logic [RW-1:0]        t_x, acc_x, res;
  logic [ACC_WIDTH-1:0] res_n;
  logic                 clamp;

`ifdef LCV_MUL_ACC_PIPE_SAT_EN
  logic ovf_q, ovf_d;
  logic fits;
`endif

  // Global advance: the pipeline moves only when the output register can be refilled.
  always_comb begin
    adv      = !out_valid_q || out_ready;
    in_ready = adv && rst;
  end

  // Stage 2 arithmetic: sign-extended product plus addend plus carry.
  always_comb begin
    a_x  = PW'($signed(a1_q));
    b_x  = PW'($signed(b1_q));
    prod = a_x * b_x;
    term = TW'($signed(prod)) + TW'($signed(c1_q)) + TW'(cin1_q);
  end

  // Stage 3 arithmetic: op-selected result, then narrowing to ACC_WIDTH.
  always_comb begin
    t_x   = RW'($signed(t2_q));
    acc_x = RW'($signed(acc_q));
    res   = t_x;
    clamp = 1'b0;
    case (op2_q)
      OP_ACC:  res = acc_x + t_x;
      OP_SUB:  res = acc_x - t_x;
      default: res = t_x;
    endcase
`ifdef LCV_MUL_ACC_PIPE_SAT_EN
    fits  = (&res[RW-1:ACC_WIDTH-1]) || !(|res[RW-1:ACC_WIDTH-1]);
    clamp = !fits;
    if (fits)
      res_n = res[ACC_WIDTH-1:0];
    else if (res[RW-1])
      res_n = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    else
      res_n = {1'b0, {(ACC_WIDTH-1){1'b1}}};
`else
    res_n = res;
`endif
  end

  // Next-state for every stage; everything holds while adv is low.
  always_comb begin
    v1_d        = v1_q;
    a1_d        = a1_q;
    b1_d        = b1_q;
    c1_d        = c1_q;
    cin1_d      = cin1_q;
    op1_d       = op1_q;
    v2_d        = v2_q;
    t2_d        = t2_q;
    op2_d       = op2_q;
    out_valid_d = out_valid_q;
    outp_d      = outp_q;
    acc_d       = acc_q;
`ifdef LCV_MUL_ACC_PIPE_SAT_EN
    ovf_d       = ovf_q;
`endif
    if (adv) begin
      v1_d        = in_valid;
      a1_d        = a;
      b1_d        = b;
      c1_d        = c;
      cin1_d      = carry_in;
      op1_d       = op;
      v2_d        = v1_q;
      t2_d        = term;
      op2_d       = op1_q;
      out_valid_d = v2_q;
      // Bubbles leave outp and the accumulator untouched.
      if (v2_q) begin
        outp_d = res_n;
        if (op2_q != OP_PASS) acc_d = res_n;
`ifdef LCV_MUL_ACC_PIPE_SAT_EN
        ovf_d = ovf_q || clamp;
`endif
      end
    end
  end

  // Pipeline registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      v1_q        <= 1'b0;
      a1_q        <= '0;
      b1_q        <= '0;
      c1_q        <= '0;
      cin1_q      <= 1'b0;
      op1_q       <= OP_PASS;
      v2_q        <= 1'b0;
      t2_q        <= '0;
      op2_q       <= OP_PASS;
      out_valid_q <= 1'b0;
      outp_q      <= '0;
      acc_q       <= '0;
`ifdef LCV_MUL_ACC_PIPE_SAT_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      v1_q        <= v1_d;
      a1_q        <= a1_d;
      b1_q        <= b1_d;
      c1_q        <= c1_d;
      cin1_q      <= cin1_d;
      op1_q       <= op1_d;
      v2_q        <= v2_d;
      t2_q        <= t2_d;
      op2_q       <= op2_d;
      out_valid_q <= out_valid_d;
      outp_q      <= outp_d;
      acc_q       <= acc_d;
`ifdef LCV_MUL_ACC_PIPE_SAT_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign outp      = outp_q;
`ifdef LCV_MUL_ACC_PIPE_SAT_EN
  assign ovf       = ovf_q;
`else
  assign ovf       = 1'b0;
`endif

endmodule

// File: tb/tb_lcv_mul_acc_pipe.sv
// Bench for lcv_mul_acc_pipe: directed cases plus randomized traffic against an arithmetic reference model.
// Expected results are queued at accept time; a monitor pops and compares on each output transfer.
// Downstream ready is driven always-high, randomly, or held low to exercise stalls.
module tb_lcv_mul_acc_pipe;

  localparam longint MAXV = 64'sd4294967295;
  localparam longint MINV = -64'sd4294967296;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, carry_in, out_valid, out_ready, ovf;
  logic [15:0] a, b;
  logic [32:0] c, outp;
  logic [1:0]  op;

  always #5 clk = ~clk;

  lcv_mul_acc_pipe #(.IN_WIDTH(16), .ACC_WIDTH(33)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .carry_in(carry_in), .op(op),
    .out_valid(out_valid), .out_ready(out_ready), .outp(outp), .ovf(ovf)
  );

  typedef struct {
    longint val;
    bit     ovf;
  } exp_t;

  exp_t   exp_q[$];
  longint obs_q[$];
  int     obs_cyc[$];
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     ready_mode = 0;
  longint m_acc = 0;
  bit     m_ovf = 0;
  bit     bp_done = 0;

  function automatic longint sext33(logic [32:0] w);
    return longint'($signed(w));
  endfunction

  task automatic check(string name, longint act, longint expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // Reference model: spec arithmetic on 64-bit integers, acc updated in accept order.
  task automatic model_accept(input logic [1:0] op_i, input int ai, input int bi,
                              input longint ci, input bit cin_i);
    longint t, r;
    bit     cl;
    exp_t   e;
    cl = 0;
    t  = longint'(ai) * longint'(bi) + ci + longint'(cin_i);
    case (op_i)
      2'd2:    r = m_acc + t;
      2'd3:    r = m_acc - t;
      default: r = t;
    endcase
`ifdef LCV_MUL_ACC_PIPE_SAT_EN
    if (r > MAXV) begin r = MAXV; cl = 1; end
    else if (r < MINV) begin r = MINV; cl = 1; end
`else
    r = sext33(r[32:0]);
`endif
    if (op_i != 2'd0) m_acc = r;
    m_ovf = m_ovf | cl;
    e.val = r;
    e.ovf = m_ovf;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [1:0] op_i, input int ai, input int bi,
                      input longint ci, input bit cin_i);
    int w;
    w = 0;
    @(negedge clk);
    in_valid = 1'b1;
    op       = op_i;
    a        = ai[15:0];
    b        = bi[15:0];
    c        = ci[32:0];
    carry_in = cin_i;
    #1;
    while (!in_ready && w < 300) begin
      @(negedge clk);
      #1;
      w++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, expected 1", w);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      model_accept(op_i, ai, bi, ci, cin_i);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 500) begin
      @(negedge clk);
      #2;
      w++;
    end
    check("drain_pending", exp_q.size(), 0);
  endtask

  // Downstream ready generator.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: scoreboard pop on transfer, plus hold-stability under stall.
  initial begin
    bit     prev_stall;
    longint prev_outp;
    exp_t   e;
    prev_stall = 0;
    prev_outp  = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", longint'(out_valid), 1);
          check("hold_outp", sext33(outp), prev_outp);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got outp %0d, expected no output", sext33(outp));
          end else begin
            e = exp_q.pop_front();
            check("outp", sext33(outp), e.val);
            check("ovf", longint'(ovf), longint'(e.ovf));
          end
          obs_q.push_back(sext33(outp));
          obs_cyc.push_back(cyc);
        end
        prev_stall = out_valid && !out_ready;
        prev_outp  = sext33(outp);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    longint ex[5];
    int     w;
    rst = 1'b0; in_valid = 1'b0; a = '0; b = '0; c = '0; carry_in = 1'b0; op = 2'd0;

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    check("rst_in_ready", longint'(in_ready), 0);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_outp", sext33(outp), 0);
    check("rst_ovf", longint'(ovf), 0);
    @(negedge clk);
    rst = 1'b1;

    // PASS with latency check, then show acc untouched.
    obs_q.delete(); obs_cyc.delete();
    send(2'd0, 3, -4, 5, 1);
    @(negedge clk); #1; check("lat_c1", longint'(out_valid), 0);
    @(negedge clk); #1; check("lat_c2", longint'(out_valid), 0);
    @(negedge clk); #1; check("lat_c3", longint'(out_valid), 1);
    send(2'd2, 0, 0, 0, 0);
    drain();
    check("pass_n", obs_q.size(), 2);
    check("pass_val", obs_q[0], -6);
    check("pass_acc0", obs_q[1], 0);

    // LOAD then back-to-back ACC.
    obs_q.delete(); obs_cyc.delete();
    send(2'd1, 100, 100, 0, 0);
    repeat (3) send(2'd2, -2, 3, 1, 0);
    drain();
    ex = '{10000, 9995, 9990, 9985, 0};
    check("acc_n", obs_q.size(), 4);
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      check($sformatf("acc_val%0d", i), obs_q[i], ex[i]);
      if (i > 0) check($sformatf("acc_consec%0d", i), obs_cyc[i] - obs_cyc[i-1], 1);
    end

    // LOAD then SUB.
    obs_q.delete(); obs_cyc.delete();
    send(2'd1, 5, 10, 0, 0);
    send(2'd3, 2, 2, 0, 1);
    drain();
    check("sub_n", obs_q.size(), 2);
    check("sub_load", obs_q[0], 50);
    check("sub_val", obs_q[1], 45);

    // Backpressure.
    obs_q.delete(); obs_cyc.delete();
    ready_mode = 2;
    repeat (2) @(negedge clk);
    bp_done = 0;
    fork
      begin
        send(2'd1, 0, 0, 0, 0);
        repeat (4) send(2'd2, 1, 1, 0, 0);
        bp_done = 1;
      end
    join_none
    repeat (6) @(negedge clk);
    #1;
    check("bp_in_ready", longint'(in_ready), 0);
    check("bp_out_valid", longint'(out_valid), 1);
    check("bp_outp", sext33(outp), 0);
    ready_mode = 0;
    w = 0;
    while (!bp_done && w < 300) begin
      @(negedge clk);
      w++;
    end
    check("bp_sender_done", longint'(bp_done), 1);
    drain();
    ex = '{0, 1, 2, 3, 4};
    check("bp_n", obs_q.size(), 5);
    for (int i = 0; i < 5 && i < obs_q.size(); i++)
      check($sformatf("bp_val%0d", i), obs_q[i], ex[i]);

    // Overflow boundary.
    obs_q.delete(); obs_cyc.delete();
    send(2'd1, 0, 0, MAXV, 0);
    send(2'd2, 1, 1, 0, 0);
    drain();
    check("ovf_n", obs_q.size(), 2);
    check("ovf_load", obs_q[0], MAXV);
`ifdef LCV_MUL_ACC_PIPE_SAT_EN
    check("ovf_val", obs_q[1], MAXV);
    check("ovf_flag", longint'(ovf), 1);
`else
    check("ovf_val", obs_q[1], MINV);
    check("ovf_flag", longint'(ovf), 0);
`endif

    // Randomized traffic with random downstream readiness.
    ready_mode = 1;
    for (int i = 0; i < 300; i++) begin
      logic [32:0] cr;
      longint      ci;
      int          ai, bi;
      ai = int'($urandom_range(0, 65535)) - 32768;
      bi = int'($urandom_range(0, 65535)) - 32768;
      cr[31:0] = $urandom;
      cr[32]   = 1'($urandom_range(0, 1));
      ci = ($urandom_range(0, 1) == 1) ? sext33(cr) : longint'($urandom_range(0, 200)) - 100;
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      send(2'($urandom_range(0, 3)), ai, bi, ci, 1'($urandom_range(0, 1)));
    end
    drain();
    ready_mode = 0;

    // Reset with two transactions in flight.
    obs_q.delete(); obs_cyc.delete();
    send(2'd2, 1, 1, 0, 0);
    send(2'd2, 1, 1, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    m_acc = 0;
    m_ovf = 0;
    @(negedge clk);
    #1;
    check("mid_rst_out_valid", longint'(out_valid), 0);
    check("mid_rst_in_ready", longint'(in_ready), 0);
    check("mid_rst_ovf", longint'(ovf), 0);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    check("mid_rst_dropped", longint'(out_valid), 0);
    send(2'd2, 2, 2, 0, 0);
    drain();
    check("mid_rst_n", obs_q.size(), 1);
    check("mid_rst_val", obs_q[0], 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
